// File: rtl/ysyx_22050039_idu_pipe.sv
// RV64I decode stage: coarse decode, GPR file and busy-bit scoreboard, one registered bundle per accept.
// Define YSYX_22050039_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module ysyx_22050039_idu_pipe #(
  parameter int XLEN     = 64,
  parameter int NR_REG   = 32,
  parameter int REG_SEL  = 5,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [5:0]          out_type,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [REG_SEL-1:0]  out_rd,
  output logic                out_rd_wen,
  output logic                out_pc_wen,
  output logic [XLEN-1:0]     out_src1,
  output logic [XLEN-1:0]     out_src2,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_ebreak,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [REG_SEL-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_RW   = 7'b0111011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_IW   = 7'b0011011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // type one-hot is {R,I,S,B,U,J}
  function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] i, input logic [5:0] t);
    logic signed [XLEN-1:0] v;
    v = '0;
    if (t[4])      v = {{(XLEN-12){i[31]}}, i[31:20]};
    else if (t[3]) v = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
    else if (t[2]) v = {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    else if (t[1]) v = {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
    else if (t[0]) v = {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    return v;
  endfunction

  logic [XLEN-1:0]    regs_q [NR_REG];
  logic [NR_REG-1:0]  busy_q, busy_d;
  logic               vld_q;
  logic [XLEN-1:0]    pc_q, src1_q, src2_q, imm_q;
  logic [5:0]         type_q;
  logic [6:0]         opcode_q, funct7_q;
  logic [2:0]         funct3_q;
  logic [REG_SEL-1:0] rd_q;
  logic               rd_wen_q, pc_wen_q, ebreak_q, illegal_q;

  logic [6:0]         opcode;
  logic [REG_SEL-1:0] rd, rs1, rs2;
  logic [5:0]         typ;
  logic               is_ebreak, is_illegal, rd_wen, pc_wen, uses_rs1, uses_rs2;
  logic               wb_hit1, wb_hit2, wb_hitd, hazard, accept;
  logic [XLEN-1:0]    opnd1, opnd2, src1, src2;
  logic signed [XLEN-1:0] imm;

  always_comb begin
    opcode    = in_inst[6:0];
    rd        = in_inst[11:7];
    rs1       = in_inst[19:15];
    rs2       = in_inst[24:20];
    is_ebreak = (in_inst == INST_LEN'(32'h0010_0073));
    typ       = 6'b0;
    case (opcode)
      OP_R, OP_RW:                      typ = 6'b100000;
      OP_I, OP_IW, OP_LD, OP_JALR:      typ = 6'b010000;
      OP_S:                             typ = 6'b001000;
      OP_B:                             typ = 6'b000100;
      OP_LUI, OP_AUI:                   typ = 6'b000010;
      OP_JAL:                           typ = 6'b000001;
      default:                          typ = 6'b0;
    endcase
    is_illegal = (typ == 6'b0) && !is_ebreak;
    rd_wen     = (typ[5] | typ[4] | typ[1] | typ[0]) && (rd != '0);
    pc_wen     = typ[2] | typ[0] | (opcode == OP_JALR);
    uses_rs1   = typ[5] | typ[4] | typ[3] | typ[2];
    uses_rs2   = typ[5] | typ[3] | typ[2];
    imm        = imm_gen(in_inst[31:0], typ);
  end

  // A writeback landing this cycle can satisfy a pending source or destination
`ifdef YSYX_22050039_WB_BYPASS_EN
  assign wb_hit1 = wb_valid && (wb_rd == rs1) && (rs1 != '0);
  assign wb_hit2 = wb_valid && (wb_rd == rs2) && (rs2 != '0);
  assign wb_hitd = wb_valid && (wb_rd == rd)  && (rd  != '0);
`else
  assign wb_hit1 = 1'b0;
  assign wb_hit2 = 1'b0;
  assign wb_hitd = 1'b0;
`endif

  always_comb begin
    opnd1    = wb_hit1 ? wb_data : regs_q[rs1];
    opnd2    = wb_hit2 ? wb_data : regs_q[rs2];
    src1     = uses_rs1 ? opnd1 : '0;
    src2     = uses_rs2 ? opnd2 : '0;
    hazard   = (uses_rs1 && busy_q[rs1] && !wb_hit1) ||
               (uses_rs2 && busy_q[rs2] && !wb_hit2) ||
               (rd_wen   && busy_q[rd]  && !wb_hitd);
    in_ready = (!vld_q || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Clear on writeback first so a same-edge re-issue to that index keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && rd_wen) busy_d[rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wb_valid && (wb_rd != '0)) regs_q[wb_rd] <= wb_data;
    end
  end

  // Decode -> EXU bundle register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      pc_q      <= '0;
      type_q    <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      pc_wen_q  <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      ebreak_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (flush)          vld_q <= 1'b0;
      else if (accept)    vld_q <= 1'b1;
      else if (out_ready) vld_q <= 1'b0;
      if (accept) begin
        pc_q      <= in_pc;
        type_q    <= typ;
        opcode_q  <= opcode;
        funct3_q  <= in_inst[14:12];
        funct7_q  <= in_inst[31:25];
        rd_q      <= rd;
        rd_wen_q  <= rd_wen;
        pc_wen_q  <= pc_wen;
        src1_q    <= src1;
        src2_q    <= src2;
        imm_q     <= imm;
        ebreak_q  <= is_ebreak;
        illegal_q <= is_illegal;
      end
    end
  end

  assign out_valid   = vld_q;
  assign out_pc      = pc_q;
  assign out_type    = type_q;
  assign out_opcode  = opcode_q;
  assign out_funct3  = funct3_q;
  assign out_funct7  = funct7_q;
  assign out_rd      = rd_q;
  assign out_rd_wen  = rd_wen_q;
  assign out_pc_wen  = pc_wen_q;
  assign out_src1    = src1_q;
  assign out_src2    = src2_q;
  assign out_imm     = imm_q;
  assign out_ebreak  = ebreak_q;
  assign out_illegal = illegal_q;

endmodule
